// File: rtl/mca_tree_as_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mca_tree_as_pkg
// Description : Shared constants and elaboration helpers for the multi-clock
//               add/subtract tree. The helpers cover tree depth, accumulator
//               width, nodes per stage, and output saturation.
// Revision    : 1.0  initial release
// ============================================================================
package mca_tree_as_pkg;

  // Widest value the saturation helper handles. Callers sign-extend into it.
  localparam int MCA_MAX_W = 128;

  // Smallest d >= 1 with l**d >= k.
  function automatic int mca_depth(input int k, input int l);
    longint p;
    int     d;
    p = longint'(l);
    d = 1;
    for (int i = 0; i < 62; i++) begin
      if (p < longint'(k)) begin
        p = p * longint'(l);
        d = d + 1;
      end
    end
    return d;
  endfunction

  // Wide enough for K full-scale signed coefficients, added or subtracted.
  function automatic int mca_acc_width(input int k, input int w);
    return w + $clog2(k) + 1;
  endfunction

  // Number of nodes in stage j: ceil(k / l**j), computed iteratively.
  function automatic int mca_nodes(input int k, input int l, input int j);
    int n;
    n = k;
    for (int i = 0; i < j; i++) begin
      n = (n + l - 1) / l;
    end
    return n;
  endfunction

  // Clamp a sign-extended value into the signed range of width_out bits.
  function automatic logic signed [MCA_MAX_W-1:0] mca_sat(
    input logic signed [MCA_MAX_W-1:0] value,
    input int                          width_out
  );
    logic signed [MCA_MAX_W-1:0] hi;
    logic signed [MCA_MAX_W-1:0] lo;
    hi = (MCA_MAX_W'(1) <<< (width_out - 1)) - 1;
    lo = -hi - 1;
    if (value > hi) begin
      return hi;
    end else if (value < lo) begin
      return lo;
    end
    return value;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mca_tree_as_serial_acc.sv
`default_nettype none
// ============================================================================
// Module      : mca_serial_acc
// Description : One tree node. It walks L operands, one per clock, selected by
//               the stage step counter, and adds or subtracts each operand into
//               an accumulator. The first step overwrites the accumulator
//               instead of adding to it, so no separate clear cycle is needed.
//               The final sum goes into a result register that holds steady
//               while the next stage reads it.
// Ports       : clk, reset      clock, synchronous active-high reset
//               en              stage busy; the node steps only while high
//               step            operand index for this cycle (0..L-1)
//               ops             L operands, WIDTH_ACC bits each
//               signs           per-operand control, 1 = add, 0 = subtract
//               result          registered final sum of the last walk
//               sum_next        combinational accumulator value for this step
// Revision    : 1.0  initial release
// ============================================================================
module mca_serial_acc #(
  parameter  int WIDTH_ACC = 32,
  parameter  int L         = 16,
  parameter  bit USE_SIGN  = 1'b1,
  localparam int STEP_W    = $clog2(L)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              en,
  input  logic [STEP_W-1:0]                 step,
  input  logic [L-1:0][WIDTH_ACC-1:0]       ops,
  input  logic [L-1:0]                      signs,
  output logic signed [WIDTH_ACC-1:0]       result,
  output logic signed [WIDTH_ACC-1:0]       sum_next
);

  logic signed [WIDTH_ACC-1:0] r_acc;
  logic signed [WIDTH_ACC-1:0] w_operand;
  logic signed [WIDTH_ACC-1:0] w_base;
  logic                        w_add;

  always_comb begin
    w_operand = signed'(ops[step]);
    // Later stages combine partial sums, so they always add.
    w_add     = USE_SIGN ? signs[step] : 1'b1;
    w_base    = (step == '0) ? '0 : r_acc;
    sum_next  = w_add ? (w_base + w_operand) : (w_base - w_operand);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc  <= '0;
      result <= '0;
    end else if (en) begin
      r_acc <= sum_next;
      if (step == STEP_W'(L - 1)) begin
        result <= sum_next;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mca_tree_as.sv
`default_nettype none
// ============================================================================
// Module      : mca_tree_as
// Description : Pipelined multi-clock add/subtract tree. It computes the signed
//               sum of K coefficients and adds or subtracts each one according
//               to its S bit. There are D stages of serial L-operand nodes.
//               One sample can be in flight per stage.
//               Compile-time option MCA_TREE_SAT_EN: when defined, the output
//               saturates on narrowing. When undefined, it wraps.
// Ports       : clk, reset      clock, synchronous active-high reset
//               start / ready   request a sample / request accepted when ready
//               H_matrix        K signed coefficients (captured on accept)
//               S_matrix        K control bits, 1 = add, 0 = subtract
//               sample          signed result, held until the next valid
//               valid           one-cycle pulse when sample updates
//               start_dropped   pulse when start arrives while not ready
// Revision    : 1.0  initial release
// ============================================================================
module mca_tree_as
  import mca_tree_as_pkg::*;
#(
  parameter int K                 = 256,
  parameter int WIDTH_COEFFICIENT = 32,
  parameter int MCA_NUM_ADDITIONS = 16,
  parameter int WIDTH_OUT         = 32
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  output logic                                 ready,
  input  logic [K-1:0][WIDTH_COEFFICIENT-1:0]  H_matrix,
  input  logic [K-1:0]                         S_matrix,
  output logic signed [WIDTH_OUT-1:0]          sample,
  output logic                                 valid,
  output logic                                 start_dropped
);

  localparam int L         = MCA_NUM_ADDITIONS;
  localparam int D         = mca_depth(K, L);
  localparam int WIDTH_ACC = mca_acc_width(K, WIDTH_COEFFICIENT);
  localparam int STEP_W    = $clog2(L);
  localparam int N1        = mca_nodes(K, L, 1);
  localparam int NPAD      = N1 * L;

  // Stage-0 operand bank.
  logic [K-1:0][WIDTH_COEFFICIENT-1:0] r_h;
  logic [K-1:0]                        r_s;

  // w_res[j] holds the operands that feed stage j+1, zero-padded to NPAD.
  logic signed [WIDTH_ACC-1:0] w_res [0:D-1][0:NPAD-1];
  logic [NPAD-1:0]             w_sgn0;
  logic signed [WIDTH_ACC-1:0] w_final;
  logic signed [WIDTH_OUT-1:0] w_conv;

  // Per-stage controllers. All nodes in a stage share busy and step.
  logic [D:1]        r_busy;
  logic [STEP_W-1:0] r_cnt [1:D];
  logic [D:1]        w_done;
  logic [D:1]        w_go;
  logic              w_accept;

  assign ready         = ~r_busy[1];
  assign w_accept      = start & ready & ~reset;
  assign start_dropped = start & ~ready & ~reset;

  always_comb begin
    w_done = '0;
    w_go   = '0;
    for (int j = 1; j <= D; j++) begin
      w_done[j] = r_busy[j] && (r_cnt[j] == STEP_W'(L - 1));
    end
    w_go[1] = w_accept;
    // Each stage starts in the cycle after the previous stage completes.
    for (int j = 2; j <= D; j++) begin
      w_go[j] = w_done[j-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= '0;
      for (int j = 1; j <= D; j++) begin
        r_cnt[j] <= '0;
      end
    end else begin
      for (int j = 1; j <= D; j++) begin
        if (w_go[j]) begin
          r_busy[j] <= 1'b1;
          r_cnt[j]  <= '0;
        end else if (w_done[j]) begin
          r_busy[j] <= 1'b0;
          r_cnt[j]  <= '0;
        end else if (r_busy[j]) begin
          r_cnt[j]  <= r_cnt[j] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_h <= '0;
      r_s <= '0;
    end else if (w_accept) begin
      r_h <= H_matrix;
      r_s <= S_matrix;
    end
  end

  // Sign-extend the captured coefficients. Pad entries beyond K with zero.
  for (genvar i = 0; i < NPAD; i++) begin : g_bank
    if (i < K) begin : g_real
      assign w_res[0][i] = WIDTH_ACC'(signed'(r_h[i]));
      assign w_sgn0[i]   = r_s[i];
    end else begin : g_pad
      assign w_res[0][i] = '0;
      assign w_sgn0[i]   = 1'b1;
    end
  end

  for (genvar j = 1; j <= D; j++) begin : g_stage
    localparam int NJ = mca_nodes(K, L, j);

    for (genvar n = 0; n < NJ; n++) begin : g_node
      logic [L-1:0][WIDTH_ACC-1:0] w_ops;
      logic [L-1:0]                w_sg;

      for (genvar s = 0; s < L; s++) begin : g_op
        assign w_ops[s] = w_res[j-1][n*L+s];
        if (j == 1) begin : g_sgn
          assign w_sg[s] = w_sgn0[n*L+s];
        end else begin : g_add
          assign w_sg[s] = 1'b1;
        end
      end

      if (j < D) begin : g_mid
        logic signed [WIDTH_ACC-1:0] w_nxt_unused;
        mca_serial_acc #(
          .WIDTH_ACC (WIDTH_ACC),
          .L         (L),
          .USE_SIGN  (j == 1)
        ) u_node (
          .clk      (clk),
          .reset    (reset),
          .en       (r_busy[j]),
          .step     (r_cnt[j]),
          .ops      (w_ops),
          .signs    (w_sg),
          .result   (w_res[j][n]),
          .sum_next (w_nxt_unused)
        );
      end else begin : g_last
        // The last stage has a single node. Its final step feeds the output
        // register directly, which saves one cycle of latency.
        logic signed [WIDTH_ACC-1:0] w_result_unused;
        mca_serial_acc #(
          .WIDTH_ACC (WIDTH_ACC),
          .L         (L),
          .USE_SIGN  (j == 1)
        ) u_node (
          .clk      (clk),
          .reset    (reset),
          .en       (r_busy[j]),
          .step     (r_cnt[j]),
          .ops      (w_ops),
          .signs    (w_sg),
          .result   (w_result_unused),
          .sum_next (w_final)
        );
      end
    end

    if (j < D) begin : g_zero
      for (genvar n = NJ; n < NPAD; n++) begin : g_z
        assign w_res[j][n] = '0;
      end
    end
  end

  if (WIDTH_OUT >= WIDTH_ACC) begin : g_extend
    assign w_conv = WIDTH_OUT'(w_final);
  end else begin : g_narrow
`ifdef MCA_TREE_SAT_EN
    assign w_conv = WIDTH_OUT'(mca_sat(MCA_MAX_W'(w_final), WIDTH_OUT));
`else
    assign w_conv = w_final[WIDTH_OUT-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid  <= 1'b0;
      sample <= '0;
    end else begin
      valid <= w_done[D];
      if (w_done[D]) begin
        sample <= w_conv;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mca_tree_as.sv
`default_nettype none
// ============================================================================
// Module      : tb_mca_tree_as
// Description : Directed bench for mca_tree_as. Three instances are used:
//               K=16/L=4/W=8 with a 32-bit output, the same tree with an
//               8-bit output for the saturate/wrap check, and K=10 for the
//               padding check. All expected values are hand-computed.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mca_tree_as;

  localparam int K   = 16;
  localparam int L   = 4;
  localparam int W   = 8;
  localparam int K10 = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset;
  logic                 start;
  logic [K-1:0][W-1:0]  h;
  logic [K-1:0]         s;
  logic                 ready, valid, dropped;
  logic signed [31:0]   sample;
  logic                 ready8, valid8, dropped8;
  logic signed [7:0]    sample8;

  logic                   start10;
  logic [K10-1:0][W-1:0]  h10;
  logic [K10-1:0]         s10;
  logic                   ready10, valid10, dropped10;
  logic signed [31:0]     sample10;

  int passed;
  int total;

  mca_tree_as #(.K(K), .WIDTH_COEFFICIENT(W), .MCA_NUM_ADDITIONS(L), .WIDTH_OUT(32)) u_dut (
    .clk(clk), .reset(reset), .start(start), .ready(ready), .H_matrix(h), .S_matrix(s),
    .sample(sample), .valid(valid), .start_dropped(dropped));

  mca_tree_as #(.K(K), .WIDTH_COEFFICIENT(W), .MCA_NUM_ADDITIONS(L), .WIDTH_OUT(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start), .ready(ready8), .H_matrix(h), .S_matrix(s),
    .sample(sample8), .valid(valid8), .start_dropped(dropped8));

  mca_tree_as #(.K(K10), .WIDTH_COEFFICIENT(W), .MCA_NUM_ADDITIONS(L), .WIDTH_OUT(32)) u_dut10 (
    .clk(clk), .reset(reset), .start(start10), .ready(ready10), .H_matrix(h10), .S_matrix(s10),
    .sample(sample10), .valid(valid10), .start_dropped(dropped10));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int hv, input int sv);
    for (int i = 0; i < K; i++) begin
      h[i] = W'(hv);
      s[i] = sv[0];
    end
  endtask

  // Start one sample on the K=16 instances and wait a bounded time for valid.
  // lat is -1 if valid never arrives.
  task automatic run16(output int lat, output logic signed [31:0] smp,
                       output logic signed [7:0] smp8);
    lat   = -1;
    smp   = '0;
    smp8  = '0;
    start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      start = 1'b0;
      if (valid) begin
        lat  = c;
        smp  = sample;
        smp8 = sample8;
        break;
      end
    end
    start = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    int nv;
    reset = 1'b1;
    start = 1'b1;
    fill(1, 1);
    tick(); tick(); tick();
    reset = 1'b0;
    start = 1'b0;
    #1;
    total++; if (ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", ready); else passed++;
    total++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", valid); else passed++;
    total++; if (sample !== 32'sd0) $display("FAIL reset_sample: got %0d expected 0", sample); else passed++;
    total++; if (dropped !== 1'b0) $display("FAIL reset_dropped: got %b expected 0", dropped); else passed++;
    nv = 0;
    for (int c = 0; c < 14; c++) begin
      tick();
      if (valid) nv++;
    end
    total++; if (nv !== 0) $display("FAIL reset_start_ignored: got %0d valids expected 0", nv); else passed++;
  endtask

  task automatic test_add();
    int lat; logic signed [31:0] smp; logic signed [7:0] smp8;
    fill(1, 1);
    run16(lat, smp, smp8);
    total++; if (lat !== 9) $display("FAIL add_latency: got %0d expected 9", lat); else passed++;
    total++; if (smp !== 32'sd16) $display("FAIL add_sum: got %0d expected 16", smp); else passed++;
    total++; if (valid !== 1'b0) $display("FAIL valid_pulse: got %b expected 0", valid); else passed++;
  endtask

  task automatic test_sub();
    int lat; logic signed [31:0] smp; logic signed [7:0] smp8;
    fill(1, 0);
    run16(lat, smp, smp8);
    total++; if (lat !== 9) $display("FAIL sub_latency: got %0d expected 9", lat); else passed++;
    total++; if (smp !== -32'sd16) $display("FAIL sub_sum: got %0d expected -16", smp); else passed++;
  endtask

  task automatic test_mixed();
    int lat; logic signed [31:0] smp; logic signed [7:0] smp8;
    for (int i = 0; i < K; i++) begin
      h[i] = W'(i);
      s[i] = ((i % 2) == 0);
    end
    run16(lat, smp, smp8);
    total++; if (lat !== 9) $display("FAIL mixed_latency: got %0d expected 9", lat); else passed++;
    total++; if (smp !== -32'sd8) $display("FAIL mixed_sum: got %0d expected -8", smp); else passed++;
  endtask

  task automatic test_sat();
    int lat; logic signed [31:0] smp; logic signed [7:0] smp8;
    logic signed [7:0] exp8;
`ifdef MCA_TREE_SAT_EN
    exp8 = 8'sd127;
`else
    exp8 = -8'sd16;
`endif
    fill(127, 1);
    run16(lat, smp, smp8);
    total++; if (smp !== 32'sd2032) $display("FAIL wide_sum: got %0d expected 2032", smp); else passed++;
    total++; if (smp8 !== exp8) $display("FAIL narrow_out: got %0d expected %0d", smp8, exp8); else passed++;
  endtask

  task automatic test_back_to_back();
    int nv;
    int vc [2];
    logic signed [31:0] vs [2];
    nv = 0; vc[0] = -1; vc[1] = -1; vs[0] = '0; vs[1] = '0;
    for (int c = 0; c <= 20; c++) begin
      start = (c == 0) || (c == 3) || (c == 5);
      fill((c < 3) ? 1 : 2, 1);
      #1;
      if (c == 1) begin
        total++; if (ready !== 1'b0) $display("FAIL b2b_busy_c1: got ready %b expected 0", ready); else passed++;
      end
      if (c == 3) begin
        total++; if (dropped !== 1'b1) $display("FAIL b2b_dropped: got %b expected 1", dropped); else passed++;
      end
      if (c == 4) begin
        total++; if (dropped !== 1'b0) $display("FAIL b2b_drop_pulse: got %b expected 0", dropped); else passed++;
        total++; if (ready !== 1'b0) $display("FAIL b2b_busy_c4: got ready %b expected 0", ready); else passed++;
      end
      if (c == 5) begin
        total++; if (ready !== 1'b1) $display("FAIL b2b_ready_c5: got ready %b expected 1", ready); else passed++;
      end
      if (c == 12) begin
        total++; if (sample !== 32'sd16) $display("FAIL b2b_hold: got %0d expected 16", sample); else passed++;
      end
      if (valid) begin
        if (nv < 2) begin
          vc[nv] = c;
          vs[nv] = sample;
        end
        nv++;
      end
      tick();
    end
    start = 1'b0;
    total++; if (nv !== 2) $display("FAIL b2b_count: got %0d expected 2", nv); else passed++;
    total++; if (vc[0] !== 9) $display("FAIL b2b_cycle0: got %0d expected 9", vc[0]); else passed++;
    total++; if (vs[0] !== 32'sd16) $display("FAIL b2b_sample0: got %0d expected 16", vs[0]); else passed++;
    total++; if (vc[1] !== 14) $display("FAIL b2b_cycle1: got %0d expected 14", vc[1]); else passed++;
    total++; if (vs[1] !== 32'sd32) $display("FAIL b2b_sample1: got %0d expected 32", vs[1]); else passed++;
  endtask

  task automatic test_nonpow();
    int lat;
    logic signed [31:0] smp;
    lat = -1;
    smp = '0;
    for (int i = 0; i < K10; i++) begin
      h10[i] = W'(i + 1);
      s10[i] = 1'b1;
    end
    start10 = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      start10 = 1'b0;
      if (valid10) begin
        lat = c;
        smp = sample10;
        break;
      end
    end
    start10 = 1'b0;
    tick();
    total++; if (lat !== 9) $display("FAIL nonpow_latency: got %0d expected 9", lat); else passed++;
    total++; if (smp !== 32'sd55) $display("FAIL nonpow_sum: got %0d expected 55", smp); else passed++;
  endtask

  task automatic test_reset_inflight();
    int nv;
    int lat; logic signed [31:0] smp; logic signed [7:0] smp8;
    nv = 0;
    fill(1, 1);
    for (int c = 0; c <= 20; c++) begin
      start = (c == 0);
      reset = (c == 4);
      #1;
      if (c == 5) begin
        total++; if (ready !== 1'b1) $display("FAIL rst_ready: got %b expected 1", ready); else passed++;
        total++; if (sample !== 32'sd0) $display("FAIL rst_sample: got %0d expected 0", sample); else passed++;
      end
      if (valid) nv++;
      tick();
    end
    start = 1'b0;
    reset = 1'b0;
    total++; if (nv !== 0) $display("FAIL rst_no_valid: got %0d valids expected 0", nv); else passed++;
    fill(3, 1);
    run16(lat, smp, smp8);
    total++; if (lat !== 9) $display("FAIL rst_fresh_latency: got %0d expected 9", lat); else passed++;
    total++; if (smp !== 32'sd48) $display("FAIL rst_fresh_sum: got %0d expected 48", smp); else passed++;
  endtask

  initial begin
    passed  = 0;
    total   = 0;
    reset   = 1'b1;
    start   = 1'b0;
    start10 = 1'b0;
    h       = '0;
    s       = '0;
    h10     = '0;
    s10     = '0;
    tick();
    test_reset();
    test_add();
    test_sub();
    test_mixed();
    test_sat();
    test_back_to_back();
    test_nonpow();
    test_reset_inflight();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
